// File: rtl/shift_pin_sout_tx.sv
// Serialiser feeding an 8-bit SIPO stage: takes a byte over valid/ready and emits
// 8 shift strobes (din on dout_bit) followed by one latch strobe (le_out).
module shift_pin_sout_tx #(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:7] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sel_out,
  output logic       le_out,
  output logic       dout_bit,
  output logic       busy,
  output logic [7:0] frame_count
);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("shift_pin_sout_tx: CLK_DIV must be in 1..255");
    end
    if (GAP_CYCLES > 255) begin : g_bad_gap
      $error("shift_pin_sout_tx: GAP_CYCLES must be in 0..255");
    end
  endgenerate

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  state_t     state, state_d;
  logic [0:7] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] div_cnt;
  logic [7:0] gap_cnt;
  logic       strobe;

  // Outputs decode from registered state only, so nothing on tx_* reaches them combinationally.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state;
    strobe   = ((state == SHIFT) || (state == LATCH)) && (div_cnt == DIV_LAST);
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    sel_out  = strobe;
    le_out   = strobe && (state == LATCH);
    dout_bit = (state == SHIFT) && shreg[0];
    case (state)
      IDLE:    if (tx_valid) state_d = SHIFT;
      SHIFT:   if (strobe && (bit_cnt == 3'd7)) state_d = LATCH;
      LATCH:   if (strobe) state_d = HAS_GAP ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg   <= tx_data;
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (strobe) begin
            shreg   <= {shreg[1:7], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LATCH: begin
          if (strobe) begin
            div_cnt     <= '0;
            gap_cnt     <= '0;
            frame_count <= frame_count + 8'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_pin_sout_tx.sv
// Bench for shift_pin_sout_tx: three instances (CLK_DIV/GAP = 1/0, 4/0, 1/3), a SIPO model
// per instance, and a scoreboard of expected bits, latch bytes and strobe cycles.
module tb_shift_pin_sout_tx;

  localparam int NI = 3;

  typedef struct packed { logic b; logic [31:0] at; } bit_exp_t;
  typedef struct packed { logic [0:7] v; logic [31:0] at; } frm_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:7]    tx_data;
  logic [NI-1:0] tx_valid, tx_ready, sel, le, dbit, busy;
  logic [7:0]    fc [NI];

  shift_pin_sout_tx #(.CLK_DIV(1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .sel_out(sel[0]), .le_out(le[0]), .dout_bit(dbit[0]), .busy(busy[0]), .frame_count(fc[0]));
  shift_pin_sout_tx #(.CLK_DIV(4), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .sel_out(sel[1]), .le_out(le[1]), .dout_bit(dbit[1]), .busy(busy[1]), .frame_count(fc[1]));
  shift_pin_sout_tx #(.CLK_DIV(1), .GAP_CYCLES(3)) u2 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .sel_out(sel[2]), .le_out(le[2]), .dout_bit(dbit[2]), .busy(busy[2]), .frame_count(fc[2]));

  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit_exp_t   bit_q [NI][$];
  frm_exp_t   frm_q [NI][$];
  int         ready_at [NI];
  int         acc_last [NI];
  int         acc_prev [NI];
  logic [7:0] fc_m [NI];
  logic [0:7] sr_m [NI];
  logic [0:7] sipo [NI];
  logic       prev_sel [NI];
  logic       exp_rdy;
  bit_exp_t   be;
  frm_exp_t   fe;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: SIPO model plus scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        n_checks++;
        if ({sel[i], le[i], dbit[i], busy[i], tx_ready[i]} !== 5'b00001 || fc[i] !== 8'd0)
          $display("FAIL reset_outputs[%0d]: sel/le/dout/busy/ready=%b%b%b%b%b fc=%0d, want 00001 fc=0",
                   i, sel[i], le[i], dbit[i], busy[i], tx_ready[i], fc[i]);
        else n_pass++;
        bit_q[i].delete();
        frm_q[i].delete();
        ready_at[i] = 0;
        fc_m[i]     = 8'd0;
        prev_sel[i] = 1'b0;
      end else begin
        exp_rdy = (cyc >= ready_at[i]);
        n_checks++;
        if (tx_ready[i] !== exp_rdy || busy[i] !== !exp_rdy)
          $display("FAIL ready_busy[%0d] cyc %0d: ready=%b busy=%b, want ready=%b busy=%b",
                   i, cyc, tx_ready[i], busy[i], exp_rdy, !exp_rdy);
        else n_pass++;
        n_checks++;
        if (fc[i] !== fc_m[i])
          $display("FAIL frame_count[%0d] cyc %0d: got %0d want %0d", i, cyc, fc[i], fc_m[i]);
        else n_pass++;
        if (le[i]) begin
          n_checks++;
          if (!sel[i]) $display("FAIL le_without_sel[%0d] cyc %0d: le=1 sel=%b want sel=1", i, cyc, sel[i]);
          else n_pass++;
        end
        if (sel[i] && div_of(i) > 1) begin
          n_checks++;
          if (prev_sel[i]) $display("FAIL consecutive_sel[%0d] cyc %0d: sel high twice, want gap", i, cyc);
          else n_pass++;
        end
        if (sel[i] && !le[i]) begin
          sr_m[i] = {sr_m[i][1:7], dbit[i]};
          n_checks++;
          if (bit_q[i].size() == 0) begin
            $display("FAIL unexpected_shift[%0d] cyc %0d: got strobe, want none", i, cyc);
          end else begin
            be = bit_q[i].pop_front();
            if (dbit[i] !== be.b || cyc != int'(be.at))
              $display("FAIL shift_bit[%0d]: got bit %b at cyc %0d, want bit %b at cyc %0d",
                       i, dbit[i], cyc, be.b, be.at);
            else n_pass++;
          end
        end
        if (sel[i] && le[i]) begin
          sipo[i] = sr_m[i];
          n_checks++;
          if (frm_q[i].size() == 0) begin
            $display("FAIL unexpected_latch[%0d] cyc %0d: got latch, want none", i, cyc);
          end else begin
            fe = frm_q[i].pop_front();
            if (sipo[i] !== fe.v || cyc != int'(fe.at))
              $display("FAIL latch_byte[%0d]: got %h at cyc %0d, want %h at cyc %0d",
                       i, sipo[i], cyc, fe.v, fe.at);
            else n_pass++;
          end
          fc_m[i] = fc_m[i] + 8'd1;
        end
        prev_sel[i] = sel[i];
        if (tx_valid[i] && tx_ready[i]) begin
          for (int k = 0; k < 8; k++)
            bit_q[i].push_back('{b: tx_data[k], at: 32'(cyc + (k + 1) * div_of(i))});
          frm_q[i].push_back('{v: tx_data, at: 32'(cyc + 9 * div_of(i))});
          ready_at[i] = cyc + 9 * div_of(i) + gap_of(i) + 1;
          acc_prev[i] = acc_last[i];
          acc_last[i] = cyc;
        end
      end
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send(input int i, input logic [0:7] b);
    int n = 0;
    tx_data     = b;
    tx_valid[i] = 1'b1;
    @(negedge clk);
    while (!tx_ready[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL send_timeout[%0d]: ready never rose within 2000 cycles", i);
    end
    @(posedge clk); #1;
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((bit_q[i].size() != 0 || frm_q[i].size() != 0 || !tx_ready[i]) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 2000) $display("FAIL idle_timeout[%0d]: frame still pending after 2000 cycles", i);
    else n_pass++;
  endtask

  task automatic check_sipo(input int i, input logic [0:7] want, input string name);
    n_checks++;
    if (sipo[i] !== want) $display("FAIL %s: sipo dout got %h want %h", name, sipo[i], want);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = '0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_ready, busy, sel, le, dbit} !== {3'b111, 12'b0})
      $display("FAIL reset_state: ready=%b busy=%b sel=%b le=%b dout=%b, want 111 000 000 000 000",
               tx_ready, busy, sel, le, dbit);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send(0, 8'hA5);
    wait_idle(0);
    check_sipo(0, 8'hA5, "basic_a5");
  endtask

  task automatic test_div4();
    send(1, 8'h3C);
    wait_idle(1);
    check_sipo(1, 8'h3C, "div4_3c");
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_reset();
    tx_data     = 8'h01;
    tx_valid[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      @(negedge clk);
      while (!tx_ready[0] && n < 200) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      tx_data = 8'(j + 2);
      if (j > 0) begin
        n_checks++;
        if (acc_last[0] - acc_prev[0] != 10)
          $display("FAIL back_to_back_spacing: got %0d cycles between accepts, want 10",
                   acc_last[0] - acc_prev[0]);
        else n_pass++;
      end
    end
    tx_valid[0] = 1'b0;
    wait_idle(0);
    check_sipo(0, 8'h03, "back_to_back_last");
    n_checks++;
    if (fc[0] !== 8'd3) $display("FAIL back_to_back_count: frame_count got %0d want 3", fc[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    pulse_reset();
    send(0, 8'h00);
    wait_idle(0);
    check_sipo(0, 8'h00, "prior_frame_00");
    send(0, 8'hFF);
    while (bit_q[0].size() > 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({sel[0], le[0], dbit[0], busy[0], tx_ready[0]} !== 5'b00001 || fc[0] !== 8'd0)
      $display("FAIL reset_mid_outputs: sel/le/dout/busy/ready=%b%b%b%b%b fc=%0d, want 00001 fc=0",
               sel[0], le[0], dbit[0], busy[0], tx_ready[0], fc[0]);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_sipo(0, 8'h00, "reset_mid_no_latch");
    send(0, 8'h81);
    wait_idle(0);
    check_sipo(0, 8'h81, "after_reset_81");
  endtask

  task automatic test_gap();
    send(2, 8'hC3);
    send(2, 8'h5E);
    wait_idle(2);
    n_checks++;
    if (acc_last[2] - acc_prev[2] != 13)
      $display("FAIL gap_spacing: got %0d cycles between accepts, want 13", acc_last[2] - acc_prev[2]);
    else n_pass++;
    check_sipo(2, 8'h5E, "gap_second");
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int f = 0; f < 256; f++) begin
      if (f == 255) begin
        wait_idle(0);
        n_checks++;
        if (fc[0] !== 8'd255) $display("FAIL wrap_pre: frame_count got %0d want 255", fc[0]);
        else n_pass++;
      end
      send(0, 8'(f) ^ 8'h5A);
      repeat (4) begin
        @(posedge clk); #1;
        tx_data = 8'($urandom);
      end
    end
    wait_idle(0);
    n_checks++;
    if (fc[0] !== 8'd0) $display("FAIL wrap: frame_count got %0d want 0", fc[0]);
    else n_pass++;
    check_sipo(0, 8'hA5, "wrap_last_byte");
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      sr_m[i]     = '0;
      sipo[i]     = '0;
      fc_m[i]     = '0;
      prev_sel[i] = 1'b0;
      acc_last[i] = 0;
      acc_prev[i] = 0;
    end
    test_reset();
    test_basic();
    test_div4();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
